// File: rtl/dmem_if.sv
// dmem_if: bundles the LSU request/response handshake and the data-memory
// bus that dmem_ctrl sits between.
//   slave  modport : the controller's view (takes requests, drives memory).
//   master modport : the environment's view (LSU issuing requests plus the
//                    memory answering accesses).
// Signals:
//   req_valid/req_ready/req_op/req_addr/req_wdata : LSU request handshake
//   rsp_valid/rsp_rdata/rsp_err                   : one-cycle response
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata       : memory access strobe/data
//   mem_rdata/mem_ready                           : memory read data/complete
interface dmem_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory port controller between the LSU and a single-port
// data RAM. One request at a time: IDLE -> ACCESS -> RESP -> IDLE.
// Stores get byte enables and lane-replicated data; loads come back shifted
// down to lane 0 with upper bytes zero. A watchdog turns a hung access into
// an error response.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : dmem_if.slave (request handshake, response, memory bus)
// Parameters:
//   ADDR_W         : word-address width (byte address bits [ADDR_W+1:2])
//   TIMEOUT_CYCLES : ACCESS cycles without mem_ready before error; 0 = off
// Configuration macro:
//   DMEM_MISALIGN_TRAP_EN : when defined, misaligned half/word requests are
//   answered with an error without touching memory; when undefined they are
//   force-aligned and proceed normally.
// Op encoding: LB=000 LH=001 LW=010 SB=011 LBU=100 LHU=101 SH=110 SW=111
module dmem_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wd_q, wd_d;

  logic [1:0]        a;
  logic              misaligned;
  logic [3:0]        req_be;
  logic [31:0]       req_wd;
  logic              req_we;
  logic [31:0]       shift8, shift16, load_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

  assign a = bus.req_addr[1:0];

  // Store lane steering and misalignment detection for the request on the bus.
  // Halfwords only look at a[1] and words ignore a entirely, which gives the
  // forced-alignment behaviour when trapping is disabled.
  always_comb begin
    req_we     = 1'b0;
    req_be     = 4'b1111;
    req_wd     = 32'h0;
    misaligned = 1'b0;
    case (bus.req_op)
      OP_SB: begin
        req_we = 1'b1;
        req_be = 4'b0001 << a;
        req_wd = {4{bus.req_wdata[7:0]}};
      end
      OP_SH: begin
        req_we     = 1'b1;
        req_be     = a[1] ? 4'b1100 : 4'b0011;
        req_wd     = {2{bus.req_wdata[15:0]}};
        misaligned = a[0];
      end
      OP_SW: begin
        req_we     = 1'b1;
        req_wd     = bus.req_wdata;
        misaligned = |a;
      end
      OP_LH, OP_LHU: misaligned = a[0];
      OP_LW:         misaligned = |a;
      default: ;
    endcase
  end

  // Load data aligned to lane 0 using the offset captured at accept time.
  // Signed and unsigned loads are identical here; extension is the LSU's job.
  always_comb begin
    shift8    = bus.mem_rdata >> {off_q, 3'b000};
    shift16   = bus.mem_rdata >> {off_q[1], 4'b0000};
    load_data = bus.mem_rdata;
    case (op_q)
      OP_LB, OP_LBU: load_data = {24'h0, shift8[7:0]};
      OP_LH, OP_LHU: load_data = {16'h0, shift16[15:0]};
      default:       load_data = bus.mem_rdata;
    endcase
    if (we_q) load_data = 32'h0;
  end

  // Next-state logic. mem_ready is tested before the watchdog so a completion
  // on the timeout edge still returns data.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    off_d   = off_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          off_d   = a;
          we_d    = req_we;
          be_d    = req_be;
          addr_d  = bus.req_addr[ADDR_W+1:2];
          wdata_d = req_wd;
          wd_d    = '0;
          if (TRAP_EN && misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = load_data;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      off_q   <= off_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed self-checking bench for dmem_ctrl. Inputs change
// 1 time unit after a rising edge, outputs are sampled on falling edges.
module tb_dmem_ctrl;
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_SB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(10)) bus ();

  dmem_ctrl #(.ADDR_W(10), .TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Present a request while the controller is idle; it is taken at the next edge.
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_op = 3'b000; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", bus.req_ready); end
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.rsp_valid, bus.rsp_err} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_strobes got %b want 0000", {bus.mem_en, bus.mem_we, bus.rsp_valid, bus.rsp_err});
    end
    checks++;
    if ({bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.rsp_rdata} !== 78'h0) begin
      errors++; $display("[TB] FAIL reset_buses got be=%h addr=%h wd=%h rd=%h want 0", bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.rsp_rdata);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Minimum-latency word load, including req_ready timing around the response.
  task automatic test_lw_latency();
    bus.mem_rdata = 32'hDEADBEEF; bus.mem_ready = 1'b1;
    send(OP_LW, 32'h10, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.req_ready, bus.rsp_valid} !== 8'b1_0_1111_0_0) begin
      errors++; $display("[TB] FAIL lw_access_ctl got en=%b we=%b be=%b rdy=%b rv=%b want 1 0 1111 0 0", bus.mem_en, bus.mem_we, bus.mem_be, bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if (bus.mem_addr !== 10'd4) begin errors++; $display("[TB] FAIL lw_addr got %0d want 4", bus.mem_addr); end
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.req_ready} !== 4'b1000) begin
      errors++; $display("[TB] FAIL lw_resp_ctl got rv=%b err=%b en=%b rdy=%b want 1 0 0 0", bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.req_ready);
    end
    checks++;
    if (bus.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_rdata got %h want deadbeef", bus.rsp_rdata); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      errors++; $display("[TB] FAIL lw_back_idle got rdy=%b rv=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  // Stores: byte and halfword lane steering, response data forced to zero.
  task automatic test_stores();
    logic [2:0]  ops [2]   = '{OP_SB, OP_SH};
    logic [31:0] addrs [2] = '{32'h23, 32'h06};
    logic [31:0] wds [2]   = '{32'h0000_00A5, 32'h1234_BEEF};
    logic [3:0]  exp_be [2] = '{4'b1000, 4'b1100};
    logic [31:0] exp_wd [2] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF};
    logic [9:0]  exp_ad [2] = '{10'd8, 10'd1};
    for (int i = 0; i < 2; i++) begin
      bus.mem_ready = 1'b1;
      send(ops[i], addrs[i], wds[i]);
      @(negedge clk);
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_be} !== {2'b11, exp_be[i]}) begin
        errors++; $display("[TB] FAIL store%0d_ctl got en=%b we=%b be=%b want 1 1 %b", i, bus.mem_en, bus.mem_we, bus.mem_be, exp_be[i]);
      end
      checks++;
      if ({bus.mem_wdata, bus.mem_addr} !== {exp_wd[i], exp_ad[i]}) begin
        errors++; $display("[TB] FAIL store%0d_data got wd=%h addr=%0d want %h %0d", i, bus.mem_wdata, bus.mem_addr, exp_wd[i], exp_ad[i]);
      end
      @(posedge clk); #1; bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'h0}) begin
        errors++; $display("[TB] FAIL store%0d_resp got rv=%b err=%b rd=%h want 1 0 0", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  // Halfword load with three wait states: outputs stable for four cycles.
  task automatic test_wait_states();
    int en_cycles = 0;
    bus.mem_rdata = 32'h8001_1234; bus.mem_ready = 1'b0;
    send(OP_LH, 32'h06, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ready = 1'b1;
      @(negedge clk);
      if (bus.mem_en === 1'b1) en_cycles++;
      checks++;
      if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.rsp_valid} !== {1'b0, 4'b1111, 10'd1, 1'b0}) begin
        errors++; $display("[TB] FAIL wait_stable%0d got we=%b be=%b addr=%0d rv=%b want 0 1111 1 0", i, bus.mem_we, bus.mem_be, bus.mem_addr, bus.rsp_valid);
      end
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
    checks++;
    if (en_cycles !== 4) begin errors++; $display("[TB] FAIL wait_en_cycles got %0d want 4", en_cycles); end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'h0000_8001}) begin
      errors++; $display("[TB] FAIL wait_resp got rv=%b err=%b rd=%h want 1 0 00008001", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  // Byte/halfword loads at various offsets: lane-0 alignment, zero upper bytes.
  task automatic test_load_lanes();
    logic [2:0]  ops [4]   = '{OP_LBU, OP_LB, OP_LHU, OP_LB};
    logic [31:0] addrs [4] = '{32'h21, 32'h23, 32'h02, 32'h3C};
    logic [31:0] mds [4]   = '{32'h1122_3344, 32'h80FF_FFFF, 32'hABCD_0000, 32'h0000_00F7};
    logic [31:0] exp [4]   = '{32'h33, 32'h80, 32'hABCD, 32'hF7};
    for (int i = 0; i < 4; i++) begin
      bus.mem_rdata = mds[i]; bus.mem_ready = 1'b1;
      send(ops[i], addrs[i], 32'hFFFF_FFFF);
      @(posedge clk); #1; bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, exp[i]}) begin
        errors++; $display("[TB] FAIL load%0d got rv=%b err=%b rd=%h want 1 0 %h", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Memory never answers: watchdog ends the access after exactly 16 cycles.
  task automatic test_timeout();
    int  en_cycles = 0;
    bit  seen = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'h5555_5555;
    send(OP_LW, 32'h40, 32'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin seen = 1'b1; break; end
      if (bus.mem_en === 1'b1) en_cycles++;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL timeout_no_resp got no rsp_valid within 40 cycles want one"); end
    checks++;
    if (en_cycles !== 16) begin errors++; $display("[TB] FAIL timeout_en_cycles got %0d want 16", en_cycles); end
    checks++;
    if ({bus.rsp_err, bus.rsp_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("[TB] FAIL timeout_resp got err=%b rd=%h want 1 0", bus.rsp_err, bus.rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  // Misaligned word load: trapped or force-aligned depending on the build.
  task automatic test_misalign();
    bus.mem_rdata = 32'h1122_3344; bus.mem_ready = 1'b1;
    send(OP_LW, 32'h02, 32'h0);
    @(negedge clk);
`ifdef DMEM_MISALIGN_TRAP_EN
    checks++;
    if ({bus.mem_en, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {3'b011, 32'h0}) begin
      errors++; $display("[TB] FAIL misalign_trap got en=%b rv=%b err=%b rd=%h want 0 1 1 0", bus.mem_en, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    bus.mem_ready = 1'b0;
`else
    checks++;
    if ({bus.mem_en, bus.mem_addr, bus.mem_be} !== {1'b1, 10'd0, 4'b1111}) begin
      errors++; $display("[TB] FAIL misalign_access got en=%b addr=%0d be=%b want 1 0 1111", bus.mem_en, bus.mem_addr, bus.mem_be);
    end
    @(posedge clk); #1; bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b10, 32'h1122_3344}) begin
      errors++; $display("[TB] FAIL misalign_resp got rv=%b err=%b rd=%h want 1 0 11223344", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
`endif
    @(posedge clk); #1;
  endtask

  // Reset asserted in the middle of an access: immediate abandon, no response.
  task automatic test_reset_abort();
    bit rsp_seen = 1'b0;
    bus.mem_ready = 1'b0;
    send(OP_SW, 32'h100, 32'hCAFE_F00D);
    @(negedge clk);
    checks++;
    if ({bus.mem_en, bus.mem_addr, bus.mem_wdata} !== {1'b1, 10'h40, 32'hCAFE_F00D}) begin
      errors++; $display("[TB] FAIL abort_pre got en=%b addr=%h wd=%h want 1 040 cafef00d", bus.mem_en, bus.mem_addr, bus.mem_wdata);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_en, bus.req_ready} !== 2'b01) begin
      errors++; $display("[TB] FAIL abort_async got en=%b rdy=%b want 0 1", bus.mem_en, bus.req_ready);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) rsp_seen = 1'b1;
    end
    checks++;
    if (rsp_seen || bus.req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_after got rsp_seen=%b rdy=%b want 0 1", rsp_seen, bus.req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_lw_latency();
    test_stores();
    test_wait_states();
    test_load_lanes();
    test_timeout();
    test_misalign();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got no completion want finish before 200000");
    $fatal(1, "[TB] simulation time limit exceeded");
  end
endmodule
